pe: RTL and testbench

PE -- requirements
Module: pe

---
 rtl/pe_pkg.sv | 8 +
 rtl/pe_fp64_mac.sv | 95 +++++++++
 rtl/pe.sv | 70 +++++++
 tb/tb_pe.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared types and constants for the binary64 processing element.
package pe_pkg;
  localparam int DATA_W = 64;

  typedef logic [DATA_W-1:0] fp64_t;

  localparam fp64_t FP64_ZERO = '0;
endpackage

// File: rtl/pe_fp64_mac.sv
// Combinational binary64 a*b+c: multiply and add, each rounded to nearest-even.
module pe_fp64_mac
  import pe_pkg::*;
(
  input  fp64_t a_i,
  input  fp64_t b_i,
  input  fp64_t c_i,
  output fp64_t y_o
);
  fp64_t p;
  logic ps;
  logic [105:0] prod;
  logic [53:0] pm;
  logic pg, pst;
  logic signed [12:0] pexp;

  always_comb begin
    ps   = a_i[63] ^ b_i[63];
    prod = {53'b0, 1'b1, a_i[51:0]} * {53'b0, 1'b1, b_i[51:0]};
    if (prod[105]) begin
      pm   = {1'b0, prod[105:53]};
      pg   = prod[52];
      pst  = |prod[51:0];
      pexp = $signed({2'b0, a_i[62:52]}) + $signed({2'b0, b_i[62:52]}) - 13'sd1022;
    end else begin
      pm   = {1'b0, prod[104:52]};
      pg   = prod[51];
      pst  = |prod[50:0];
      pexp = $signed({2'b0, a_i[62:52]}) + $signed({2'b0, b_i[62:52]}) - 13'sd1023;
    end
    if (pg && (pst || pm[0])) pm = pm + 54'd1;
    if (pm[53]) begin
      pm   = pm >> 1;
      pexp = pexp + 13'sd1;
    end
    if (a_i[62:52] == 11'd0 || b_i[62:52] == 11'd0) p = {ps, 63'b0};
    else if (a_i[62:52] == 11'h7ff || b_i[62:52] == 11'h7ff) p = {ps, 11'h7ff, 52'b0};
    else if (pexp >= 13'sd2047) p = {ps, 11'h7ff, 52'b0};
    else if (pexp <= 13'sd0) p = {ps, 63'b0};
    else p = {ps, pexp[10:0], pm[51:0]};
  end

  fp64_t big, sml;
  logic [10:0] dexp;
  logic [111:0] sh;
  logic [55:0] sm, sn;
  logic [56:0] sum;
  logic [5:0] lz;
  logic [53:0] rm;
  logic rg, rs;
  logic signed [12:0] rexp;

  // Guard/round/sticky alignment: three extra bits below the 53-bit significand.
  always_comb begin
    big = p;
    sml = c_i;
    if (c_i[62:0] > p[62:0]) begin
      big = c_i;
      sml = p;
    end
    dexp = big[62:52] - sml[62:52];
    sh   = {1'b1, sml[51:0], 3'b0, 56'b0} >> dexp;
    sm   = (dexp >= 11'd56) ? 56'd1 : (sh[111:56] | {55'b0, |sh[55:0]});
    if (big[63] == sml[63]) sum = {2'b01, big[51:0], 3'b0} + {1'b0, sm};
    else sum = {2'b01, big[51:0], 3'b0} - {1'b0, sm};
    rexp = $signed({2'b0, big[62:52]});
    lz = '0;
    for (int i = 0; i < 56; i++)
      if (sum[i]) lz = 6'(55 - i);
    if (sum[56]) begin
      sn   = sum[56:1] | {55'b0, sum[0]};
      rexp = rexp + 13'sd1;
    end else begin
      sn   = sum[55:0] << lz;
      rexp = rexp - $signed({7'b0, lz});
    end
    rm = {1'b0, sn[55:3]};
    rg = sn[2];
    rs = sn[1] | sn[0];
    if (rg && (rs || rm[0])) rm = rm + 54'd1;
    if (rm[53]) begin
      rm   = rm >> 1;
      rexp = rexp + 13'sd1;
    end
    y_o = {big[63], rexp[10:0], rm[51:0]};
    if (p[62:52] == 11'h7ff) y_o = p;
    else if (c_i[62:52] == 11'h7ff) y_o = c_i;
    else if (p[62:52] == 11'd0 && c_i[62:52] == 11'd0) y_o = {p[63] & c_i[63], 63'b0};
    else if (p[62:52] == 11'd0) y_o = c_i;
    else if (c_i[62:52] == 11'd0) y_o = p;
    else if (sum == '0) y_o = FP64_ZERO;
    else if (rexp >= 13'sd2047) y_o = {big[63], 11'h7ff, 52'b0};
    else if (rexp <= 13'sd0) y_o = {big[63], 63'b0};
  end
endmodule

// File: rtl/pe.sv
// Systolic binary64 PE, weight-stationary; output-stationary mode
// is compiled in only when PE_OUTPUT_STATIONARY_EN is defined.
module pe #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              output_stationary,
  input  logic [DATA_W-1:0] in_top,
  input  logic [DATA_W-1:0] in_left,
  input  logic              preload_valid,
  input  logic [DATA_W-1:0] preload_data,
  output logic [DATA_W-1:0] out_right,
  output logic [DATA_W-1:0] out_bottom
);
  import pe_pkg::fp64_t;
  import pe_pkg::FP64_ZERO;

  fp64_t weight_q, right_q, bottom_q;
  fp64_t acc, mac_b, mac_c, mac_y;
  logic os;

`ifdef PE_OUTPUT_STATIONARY_EN
  fp64_t acc_q;

  assign os  = output_stationary;
  assign acc = acc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) acc_q <= FP64_ZERO;
    else if (os && !preload_valid) acc_q <= mac_y;
  end
`else
  logic unused_os;

  assign os        = 1'b0;
  assign acc       = FP64_ZERO;
  assign unused_os = output_stationary;
`endif

  assign mac_b = os ? in_top : weight_q;
  assign mac_c = os ? acc : in_top;

  pe_fp64_mac u_mac (
    .a_i(in_left),
    .b_i(mac_b),
    .c_i(mac_c),
    .y_o(mac_y)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      weight_q <= FP64_ZERO;
      right_q  <= FP64_ZERO;
      bottom_q <= FP64_ZERO;
    end else begin
      right_q <= in_left;
      if (!os) begin
        if (preload_valid) weight_q <= preload_data;
        bottom_q <= mac_y;
      end else if (!preload_valid) begin
        bottom_q <= in_top;
      end
    end
  end

  // A drain shows acc in the same cycle preload_valid rises.
  assign out_right  = right_q;
  assign out_bottom = (os && preload_valid) ? acc : bottom_q;
endmodule

// File: tb/tb_pe.sv
// Directed scoreboard bench for pe; expected values come from real (double) arithmetic.
module tb_pe;
  logic clk = 1'b0;
  logic reset, os, pv;
  logic [63:0] top, left, pdata, oright, obottom;

  always #5 clk = ~clk;

  pe #(.DATA_W(64)) dut (
    .clk(clk),
    .reset(reset),
    .output_stationary(os),
    .in_top(top),
    .in_left(left),
    .preload_valid(pv),
    .preload_data(pdata),
    .out_right(oright),
    .out_bottom(obottom)
  );

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] rgt_q[$];
  real w;
  real accm;

  function automatic logic [63:0] b(input real r);
    return $realtobits(r);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, expv);
    end
  endtask

  task automatic ws_drive(input real l, input real t, input bit load, input real nw);
    left  = b(l);
    top   = b(t);
    pv    = load;
    pdata = b(nw);
    exp_q.push_back(b(l * w + t));
    rgt_q.push_back(b(l));
    if (load) w = nw;
  endtask

  task automatic step(input string tag);
    logic [63:0] eb, er;
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() == 0 || rgt_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      eb = exp_q.pop_front();
      er = rgt_q.pop_front();
      chk({tag, ".bottom"}, obottom, eb);
      chk({tag, ".right"}, oright, er);
    end
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b1;
    #1;
    chk("reset.right", oright, 64'h0);
    chk("reset.bottom", obottom, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    w     = 0.0;
    accm  = 0.0;
  endtask

`ifdef PE_OUTPUT_STATIONARY_EN
  task automatic os_drive(input real l, input real t);
    left = b(l);
    top  = b(t);
    pv   = 1'b0;
    exp_q.push_back(b(t));
    rgt_q.push_back(b(l));
    accm = accm + l * t;
  endtask

  task automatic drain(input string tag);
    pv = 1'b1;
    #1;
    chk(tag, obottom, b(accm));
    @(negedge clk);
    pv = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b1;
    os    = 1'b0;
    pv    = 1'b0;
    top   = '0;
    left  = '0;
    pdata = '0;
    w     = 0.0;
    accm  = 0.0;
    repeat (2) @(negedge clk);
    chk("por.right", oright, 64'h0);
    chk("por.bottom", obottom, 64'h0);
    reset = 1'b0;

    ws_drive(0.0, 0.0, 1'b1, 2.0);
    step("ws_pre2");
    for (int i = 1; i <= 5; i++) begin
      ws_drive(real'(i), 0.5 * real'(i), 1'b0, 0.0);
      step($sformatf("ws_feed%0d", i));
    end

    ws_drive(0.0, 0.0, 1'b1, 3.0);
    step("ws_pre3");
    ws_drive(2.0, 1.0, 1'b0, 0.0);
    step("ws_w3");
    ws_drive(0.0, 0.0, 1'b1, 5.0);
    step("ws_pre5");
    ws_drive(2.0, 1.0, 1'b0, 0.0);
    step("ws_w5");

    ws_drive(0.0, 0.0, 1'b1, 7.0);
    step("ws_pre7");
    ws_drive(0.0, 0.0, 1'b0, 0.0);
    step("ws_zero");

    ws_drive(0.0, 0.0, 1'b1, -2.0);
    step("ws_preneg");
    ws_drive(3.0, 1.0, 1'b0, 0.0);
    step("ws_neg1");
    ws_drive(-4.0, 2.0, 1'b0, 0.0);
    step("ws_neg2");

    ws_drive(1.0, 0.25, 1'b1, 9.0);
    step("ws_sameedge");
    ws_drive(1.0, 0.0, 1'b0, 0.0);
    step("ws_new9");

    ws_drive(0.0, 0.0, 1'b1, 0.1);
    step("ws_pre01");
    ws_drive(0.3, 0.7, 1'b0, 0.0);
    step("ws_round");
    ws_drive(3.0, -0.3, 1'b0, 0.0);
    step("ws_cancel_part");
    ws_drive(2.0, -0.2, 1'b0, 0.0);
    step("ws_cancel_full");
    ws_drive(1.0e-20, 1.0, 1'b0, 0.0);
    step("ws_farexp");

    pulse_reset();
    ws_drive(3.0, 1.0, 1'b0, 0.0);
    step("ws_postreset");

`ifdef PE_OUTPUT_STATIONARY_EN
    pulse_reset();
    os = 1'b1;
    os_drive(1.0, 2.0);
    step("os_a1");
    os_drive(2.0, 3.0);
    step("os_a2");
    os_drive(3.0, 4.0);
    step("os_a3");
    os_drive(0.0, 0.0);
    step("os_a4");
    drain("os_drain20");

    pulse_reset();
    os_drive(5.0, 2.0);
    step("os_b1");
    drain("os_drain10");
    pulse_reset();
    os_drive(3.0, 4.0);
    step("os_c1");
    os_drive(2.0, 1.0);
    step("os_c2");
    drain("os_drain14");
    os = 1'b0;
`else
    os = 1'b1;
    ws_drive(0.0, 0.0, 1'b1, 4.0);
    step("ign_pre4");
    ws_drive(2.0, 1.0, 1'b0, 0.0);
    step("ign_ws");
    os = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
